// File: rtl/usr_seq_ctrl.sv
// usr_seq_ctrl: command sequencer for a universal shift register (load, shift N times, capture and return exiting bits).
// Optional rotate support is compiled in when the macro USR_SEQ_ROTATE_EN is defined.
module usr_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             cmd_fill,
  input  logic             cmd_rot,
  output logic [1:0]       usr_op,
  output logic [WIDTH-1:0] usr_inp,
  output logic             usr_sinr,
  output logic             usr_sinl,
  input  logic             usr_soutr,
  input  logic             usr_soutl,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_SHIFT = 2'b10,
    S_RESP  = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_cap;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic             r_fill;
  logic             w_accept;
  logic             w_sout;
  logic             w_sin;

  assign w_accept = (r_state == S_IDLE) && cmd_valid;
  assign w_sout   = r_dir ? usr_soutl : usr_soutr;
  assign usr_inp  = r_data;

`ifdef USR_SEQ_ROTATE_EN
  logic r_rot;

  // Registered rotate request for the command in flight
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_rot <= 1'b0;
    end else if (w_accept) begin
      r_rot <= cmd_rot;
    end
  end

  // Rotate feeds the exiting bit straight back into the active serial input
  assign w_sin = r_rot ? w_sout : r_fill;
`else
  logic w_unused_rot;
  assign w_unused_rot = cmd_rot;
  assign w_sin        = r_fill;
`endif

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and Moore output decode
  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    usr_op    = 2'b00;
    usr_sinr  = 1'b0;
    usr_sinl  = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = {WIDTH{1'b0}};
    busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          w_next = S_LOAD;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_LOAD: begin
        usr_op = 2'b11;
        if (r_cnt != {CNT_W{1'b0}}) begin
          w_next = S_SHIFT;
        end else begin
          w_next = S_RESP;
        end
      end
      S_SHIFT: begin
        if (r_dir) begin
          usr_op   = 2'b10;
          usr_sinl = w_sin;
        end else begin
          usr_op   = 2'b01;
          usr_sinr = w_sin;
        end
        if (r_cnt == CNT_W'(1)) begin
          w_next = S_RESP;
        end else begin
          w_next = S_SHIFT;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = r_cap;
        if (rsp_ready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_RESP;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Command registers, shift down-counter and serial-out capture
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_data <= {WIDTH{1'b0}};
      r_dir  <= 1'b0;
      r_fill <= 1'b0;
      r_cnt  <= {CNT_W{1'b0}};
      r_cap  <= {WIDTH{1'b0}};
    end else if (w_accept) begin
      r_data <= cmd_data;
      r_dir  <= cmd_dir;
      r_fill <= cmd_fill;
      r_cnt  <= cmd_cnt;
      r_cap  <= {WIDTH{1'b0}};
    end else if (r_state == S_SHIFT) begin
      // Newest bit enters at the LSB; older bits fall off the MSB when cnt exceeds WIDTH
      r_cnt <= r_cnt - CNT_W'(1);
      r_cap <= {r_cap[WIDTH-2:0], w_sout};
    end
  end

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// tb_usr_seq_ctrl: directed bench for usr_seq_ctrl driving a 4-bit universal shift register model.
// Expectations follow the USR_SEQ_ROTATE_EN setting the bench is compiled with.
module tb_usr_seq_ctrl;

  logic       clk;
  logic       clr;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_data;
  logic       cmd_dir;
  logic [2:0] cmd_cnt;
  logic       cmd_fill;
  logic       cmd_rot;
  logic [1:0] usr_op;
  logic [3:0] usr_inp;
  logic       usr_sinr;
  logic       usr_sinl;
  logic       usr_soutr;
  logic       usr_soutl;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       busy;

  logic [3:0] m_reg;
  int         total;
  int         bad;
  int         lat;

  usr_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .clr(clr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_dir(cmd_dir), .cmd_cnt(cmd_cnt), .cmd_fill(cmd_fill), .cmd_rot(cmd_rot),
    .usr_op(usr_op), .usr_inp(usr_inp), .usr_sinr(usr_sinr), .usr_sinl(usr_sinl),
    .usr_soutr(usr_soutr), .usr_soutl(usr_soutl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Universal shift register model: 00 hold, 01 right, 10 left, 11 load
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_reg <= 4'b0000;
    end else begin
      case (usr_op)
        2'b01:   m_reg <= {usr_sinr, m_reg[3:1]};
        2'b10:   m_reg <= {m_reg[2:0], usr_sinl};
        2'b11:   m_reg <= usr_inp;
        default: m_reg <= m_reg;
      endcase
    end
  end
  assign usr_soutr = m_reg[0];
  assign usr_soutl = m_reg[3];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a command in IDLE, clock it in, and check the LOAD cycle
  task automatic send(input logic [3:0] data, input logic dir, input logic [2:0] cnt,
                      input logic fill, input logic rot);
    cmd_data  = data;
    cmd_dir   = dir;
    cmd_cnt   = cnt;
    cmd_fill  = fill;
    cmd_rot   = rot;
    cmd_valid = 1'b1;
    check_val("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    lat = 1;
    check_val("busy_load", {31'd0, busy}, 32'd1);
    check_val("op_load", {30'd0, usr_op}, 32'd3);
    check_val("inp_load", {28'd0, usr_inp}, {28'd0, data});
  endtask

  // Step through SHIFT until rsp_valid, checking op and serial inputs each cycle
  task automatic wait_rsp(input logic dir, input logic fill, input logic rot,
                          input int exp_lat, input logic [3:0] exp_rsp, input logic [3:0] exp_reg);
    logic rot_on;
    logic exp_sin;
`ifdef USR_SEQ_ROTATE_EN
    rot_on = rot;
`else
    rot_on = 1'b0 & rot;
`endif
    while (!rsp_valid && lat < 40) begin
      exp_sin = rot_on ? (dir ? m_reg[3] : m_reg[0]) : fill;
      tick();
      lat++;
      if (!rsp_valid) begin
        exp_sin = rot_on ? (dir ? m_reg[3] : m_reg[0]) : fill;
        check_val("op_shift", {30'd0, usr_op}, dir ? 32'd2 : 32'd1);
        check_val("sin_active", {31'd0, dir ? usr_sinl : usr_sinr}, {31'd0, exp_sin});
        check_val("sin_inactive", {31'd0, dir ? usr_sinr : usr_sinl}, 32'd0);
      end
    end
    check_val("latency", lat, exp_lat);
    check_val("rsp_data", {28'd0, rsp_data}, {28'd0, exp_rsp});
    check_val("reg_final", {28'd0, m_reg}, {28'd0, exp_reg});
    check_val("op_resp", {30'd0, usr_op}, 32'd0);
    check_val("cmd_ready_resp", {31'd0, cmd_ready}, 32'd0);
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_val("rsp_valid_idle", {31'd0, rsp_valid}, 32'd0);
    check_val("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    lat       = 0;
    clr       = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 4'b0000;
    cmd_dir   = 1'b0;
    cmd_cnt   = 3'd0;
    cmd_fill  = 1'b0;
    cmd_rot   = 1'b0;
    rsp_ready = 1'b0;
    #2;
    check_val("rst_op", {30'd0, usr_op}, 32'd0);
    check_val("rst_inp", {28'd0, usr_inp}, 32'd0);
    check_val("rst_sin", {30'd0, usr_sinr, usr_sinl}, 32'd0);
    check_val("rst_rsp", {27'd0, rsp_valid, rsp_data}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    tick();
    clr = 1'b0;
    tick();

    // Test 1: right shift twice, fill 0
    send(4'b1011, 1'b0, 3'd2, 1'b0, 1'b0);
    wait_rsp(1'b0, 1'b0, 1'b0, 4, 4'b0011, 4'b0010);
    ack();

    // Test 2: left shift once, fill 1
    send(4'b1011, 1'b1, 3'd1, 1'b1, 1'b0);
    wait_rsp(1'b1, 1'b1, 1'b0, 3, 4'b0001, 4'b0111);
    ack();

    // Test 3: cnt=0 goes LOAD straight to RESP
    send(4'b0110, 1'b0, 3'd0, 1'b1, 1'b0);
    wait_rsp(1'b0, 1'b1, 1'b0, 2, 4'b0000, 4'b0110);
    ack();

    // Test 4: stall in RESP with a second command pending
    send(4'b0110, 1'b1, 3'd2, 1'b0, 1'b0);
    wait_rsp(1'b1, 1'b0, 1'b0, 4, 4'b0001, 4'b1000);
    cmd_data  = 4'b0101;
    cmd_dir   = 1'b0;
    cmd_cnt   = 3'd3;
    cmd_fill  = 1'b1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("hold_rsp_data", {28'd0, rsp_data}, 32'd1);
      check_val("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check_val("hold_ready", {31'd0, cmd_ready}, 32'd0);
      check_val("hold_op", {30'd0, usr_op}, 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_val("b2b_busy", {31'd0, busy}, 32'd0);
    send(4'b0101, 1'b0, 3'd3, 1'b1, 1'b0);
    wait_rsp(1'b0, 1'b1, 1'b0, 5, 4'b0101, 4'b1110);
    ack();

    // Test 5: clr in the second SHIFT cycle of a cnt=5 command
    send(4'b1011, 1'b0, 3'd5, 1'b1, 1'b0);
    tick();
    tick();
    check_val("pre_clr_op", {30'd0, usr_op}, 32'd1);
    clr = 1'b1;
    #1;
    check_val("clr_op", {30'd0, usr_op}, 32'd0);
    check_val("clr_busy", {31'd0, busy}, 32'd0);
    check_val("clr_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("clr_ready", {31'd0, cmd_ready}, 32'd1);
    check_val("clr_inp", {28'd0, usr_inp}, 32'd0);
    tick();
    clr = 1'b0;
    tick();
    send(4'b1100, 1'b1, 3'd3, 1'b1, 1'b0);
    wait_rsp(1'b1, 1'b1, 1'b0, 5, 4'b0110, 4'b0111);
    ack();

    // cnt beyond WIDTH keeps only the last four exiting bits
    send(4'b1011, 1'b0, 3'd7, 1'b0, 1'b0);
    wait_rsp(1'b0, 1'b0, 1'b0, 9, 4'b1000, 4'b0000);
    ack();

    // Test 6: rotate request
    send(4'b1011, 1'b0, 3'd4, 1'b0, 1'b1);
`ifdef USR_SEQ_ROTATE_EN
    wait_rsp(1'b0, 1'b0, 1'b1, 6, 4'b1101, 4'b1011);
`else
    wait_rsp(1'b0, 1'b0, 1'b1, 6, 4'b1101, 4'b0000);
`endif
    ack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
